// File: rtl/aes_crypt_ctrl_if.sv
// Host-side stream bundle for the AES sequencer: key load, block request and response channels.
// The host drives the master modport and the sequencer sits on the slave modport.
interface aes_crypt_ctrl_if;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key_in;
  logic         keylen;
  logic         req_valid;
  logic         req_ready;
  logic         req_dec;
  logic [127:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;

  modport master (
    output key_valid, key_in, keylen, req_valid, req_dec, req_data, rsp_ready,
    input  key_ready, req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  key_valid, key_in, keylen, req_valid, req_dec, req_data, rsp_ready,
    output key_ready, req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/aes_crypt_ctrl.sv
// Sequencer between a host valid/ready stream and the iterative AES key expansion,
// encipher and decipher blocks: one key load, then one block in flight at a time.
module aes_crypt_ctrl #(
  parameter int unsigned DEC_LAT = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_crypt_ctrl_if.slave      host,
  output logic                 kx_init,
  output logic [255:0]         kx_key,
  output logic                 kx_keylen,
  output logic [3:0]           kx_round,
  input  logic                 kx_key_ready,
  output logic                 enc_next,
  output logic [127:0]         enc_plain,
  input  logic [3:0]           enc_round,
  input  logic [127:0]         enc_cipher,
  input  logic                 enc_ready,
  output logic                 dec_start,
  output logic [127:0]         dec_cipher,
  input  logic [3:0]           dec_round,
  input  logic [127:0]         dec_plain
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CW = (DEC_LAT < 2) ? 1 : $clog2(DEC_LAT + 1);

  typedef enum logic [2:0] {
    S_NOKEY, S_KINIT, S_KWAIT, S_IDLE, S_ENC, S_DEC, S_RESP
  } state_t;

  state_t          state, state_d;
  logic            key_loaded, key_loaded_d;
  logic [TW-1:0]   timer, timer_d;
  logic [CW-1:0]   dec_cnt, dec_cnt_d;
  logic            enc_ready_q;

  logic            key_ready_d, req_ready_d, rsp_valid_d, rsp_err_d;
  logic [127:0]    rsp_data_d;
  logic            kx_init_d, kx_keylen_d, enc_next_d, dec_start_d;
  logic [255:0]    kx_key_d;
  logic [127:0]    enc_plain_d, dec_cipher_d;
  logic            key_hs, req_hs;

  // The round index belongs to the decipher only while it is running.
  assign kx_round = (state == S_DEC) ? dec_round : enc_round;

  // A simultaneous key load wins; the request stays pending.
  assign key_hs = host.key_valid && host.key_ready;
  assign req_hs = host.req_valid && host.req_ready && !host.key_valid;

  always_comb begin
    state_d      = state;
    key_loaded_d = key_loaded;
    timer_d      = timer;
    dec_cnt_d    = dec_cnt;
    rsp_data_d   = host.rsp_data;
    rsp_err_d    = host.rsp_err;
    kx_key_d     = kx_key;
    kx_keylen_d  = kx_keylen;
    enc_plain_d  = enc_plain;
    dec_cipher_d = dec_cipher;
    enc_next_d   = 1'b0;
    dec_start_d  = 1'b0;

    unique case (state)
      S_NOKEY, S_IDLE: begin
        if (key_hs) begin
          kx_key_d     = host.key_in;
          kx_keylen_d  = host.keylen;
          rsp_err_d    = 1'b0;
          key_loaded_d = 1'b0;
          state_d      = S_KINIT;
        end else if (state == S_IDLE && req_hs) begin
          timer_d = '0;
          if (host.req_dec) begin
            dec_cipher_d = host.req_data;
            dec_start_d  = 1'b1;
            dec_cnt_d    = CW'(DEC_LAT);
            state_d      = S_DEC;
          end else begin
            enc_plain_d = host.req_data;
            enc_next_d  = 1'b1;
            state_d     = S_ENC;
          end
        end
      end
      S_KINIT: begin
        timer_d = '0;
        state_d = S_KWAIT;
      end
      S_KWAIT: begin
        // timer==0 marks the first wait cycle, where kx_key_ready may still be stale.
        if (timer != '0 && kx_key_ready) begin
          key_loaded_d = 1'b1;
          state_d      = S_IDLE;
        end else if (timer == TW'(TIMEOUT)) begin
          rsp_err_d    = 1'b1;
          key_loaded_d = 1'b0;
          state_d      = S_NOKEY;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_ENC: begin
        if (enc_ready && !enc_ready_q) begin
          rsp_data_d = enc_cipher;
          state_d    = S_RESP;
        end else if (timer == TW'(TIMEOUT)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_DEC: begin
        if (dec_cnt == '0) begin
          rsp_data_d = dec_plain;
          state_d    = S_RESP;
        end else begin
          dec_cnt_d = dec_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (host.rsp_valid && host.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_NOKEY;
    endcase

    key_ready_d = (state_d == S_NOKEY) || (state_d == S_IDLE);
    req_ready_d = (state_d == S_IDLE) && key_loaded_d;
    rsp_valid_d = (state_d == S_RESP);
    kx_init_d   = (state_d == S_KINIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_NOKEY;
      key_loaded     <= 1'b0;
      timer          <= '0;
      dec_cnt        <= '0;
      enc_ready_q    <= 1'b0;
      host.key_ready <= 1'b0;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
      kx_init        <= 1'b0;
      kx_key         <= '0;
      kx_keylen      <= 1'b0;
      enc_next       <= 1'b0;
      enc_plain      <= '0;
      dec_start      <= 1'b0;
      dec_cipher     <= '0;
    end else begin
      state          <= state_d;
      key_loaded     <= key_loaded_d;
      timer          <= timer_d;
      dec_cnt        <= dec_cnt_d;
      enc_ready_q    <= enc_ready;
      host.key_ready <= key_ready_d;
      host.req_ready <= req_ready_d;
      host.rsp_valid <= rsp_valid_d;
      host.rsp_data  <= rsp_data_d;
      host.rsp_err   <= rsp_err_d;
      kx_init        <= kx_init_d;
      kx_key         <= kx_key_d;
      kx_keylen      <= kx_keylen_d;
      enc_next       <= enc_next_d;
      enc_plain      <= enc_plain_d;
      dec_start      <= dec_start_d;
      dec_cipher     <= dec_cipher_d;
    end
  end

endmodule

// File: tb/tb_aes_crypt_ctrl.sv
// Bench for aes_crypt_ctrl: behavioural key-expansion/encipher/decipher stand-ins and a
// response scoreboard fed at request time.
module tb_aes_crypt_ctrl;
  localparam int unsigned DEC_LAT = 12;
  localparam int unsigned TIMEOUT = 255;
  localparam logic [255:0] KEY0 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h5a3c96e1_0f1e2d3c_4b5a6978_8796a5b4;

  typedef struct packed {
    logic         err;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_crypt_ctrl_if h();

  logic         kx_init, kx_keylen, kx_key_ready, enc_next, enc_ready, dec_start;
  logic [255:0] kx_key;
  logic [3:0]   kx_round, enc_round, dec_round;
  logic [127:0] enc_plain, enc_cipher, dec_cipher, dec_plain;

  aes_crypt_ctrl #(.DEC_LAT(DEC_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .host(h),
    .kx_init(kx_init), .kx_key(kx_key), .kx_keylen(kx_keylen), .kx_round(kx_round),
    .kx_key_ready(kx_key_ready),
    .enc_next(enc_next), .enc_plain(enc_plain), .enc_round(enc_round),
    .enc_cipher(enc_cipher), .enc_ready(enc_ready),
    .dec_start(dec_start), .dec_cipher(dec_cipher), .dec_round(dec_round),
    .dec_plain(dec_plain)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] enc_model(input logic [127:0] p);
    return (p == PT) ? CT : (p ^ MASK);
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] c);
    return (c == CT) ? PT : (c ^ MASK);
  endfunction

  // Key expansion stand-in: ready drops one cycle late (stale level), rises 4 cycles later.
  bit kx_tie0 = 1'b0;
  logic kx_init_q = 1'b0;
  int kx_cnt = 0;
  initial kx_key_ready = 1'b0;
  always @(posedge clk) begin
    kx_init_q <= kx_init;
    if (kx_init_q) begin
      kx_key_ready <= 1'b0;
      kx_cnt       <= 4;
    end else if (kx_cnt != 0) begin
      kx_cnt <= kx_cnt - 1;
      if (kx_cnt == 1 && !kx_tie0) kx_key_ready <= 1'b1;
    end
  end

  // Encipher stand-in: ready starts high (stale), drops on enc_next, rises 6 cycles later.
  bit enc_stall = 1'b0;
  int enc_cnt = 0;
  logic [127:0] enc_pt_lat = '0;
  initial begin enc_ready = 1'b1; enc_cipher = '0; end
  assign enc_round = 4'(enc_cnt);
  always @(posedge clk) begin
    if (enc_next) begin
      enc_ready  <= 1'b0;
      enc_cnt    <= 6;
      enc_pt_lat <= enc_plain;
    end else if (enc_cnt != 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1 && !enc_stall) begin
        enc_ready  <= 1'b1;
        enc_cipher <= enc_model(enc_pt_lat);
      end
    end
  end

  // Decipher stand-in: dec_plain holds the result only in the cycle DEC_LAT after dec_start.
  int dec_cnt = 0;
  logic [127:0] dec_ct_lat = '0;
  initial dec_plain = '0;
  assign dec_round = 4'(dec_cnt) | 4'h8;
  always @(posedge clk) begin
    if (dec_start) begin
      dec_cnt    <= DEC_LAT;
      dec_plain  <= '0;
      dec_ct_lat <= dec_cipher;
    end else if (dec_cnt != 0) begin
      dec_cnt <= dec_cnt - 1;
      if (dec_cnt == 2) dec_plain <= dec_model(dec_ct_lat);
      if (dec_cnt == 1) dec_plain <= '0;
    end
  end

  // Response scoreboard plus round-index mux and kx_init pulse monitors.
  int kx_bad = 0, dec_samples = 0, kx_init_seen = 0;
  bit in_dec = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (kx_init) kx_init_seen++;
    if (!rst_n || h.rsp_valid) in_dec = 1'b0;
    else if (dec_start) in_dec = 1'b1;
    if (in_dec) begin
      dec_samples++;
      if (kx_round !== dec_round) kx_bad++;
    end else if (kx_round !== enc_round) kx_bad++;
    if (rst_n && h.rsp_valid && h.rsp_ready) begin
      if (sb.size() == 0) check_eq("rsp_unexpected", 256'(h.rsp_valid), 256'(0));
      else begin
        e = sb.pop_front();
        check_eq("rsp_data", 256'(h.rsp_data), 256'(e.data));
        check_eq("rsp_err", 256'(h.rsp_err), 256'(e.err));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] key, input logic len, input bit expect_ok);
    int n = 0;
    while (!h.key_ready && n < 600) begin tick(); n++; end
    check_eq("key_ready_wait", 256'(h.key_ready), 256'(1));
    kx_init_seen = 0;
    h.key_valid = 1'b1; h.key_in = key; h.keylen = len;
    tick();
    h.key_valid = 1'b0;
    if (expect_ok) begin
      n = 0;
      while (!h.req_ready && n < 50) begin tick(); n++; end
      check_eq("kx_latency", 256'(n), 256'(7));
      check_eq("kx_init_pulse", 256'(kx_init_seen), 256'(1));
      check_eq("kx_key", kx_key, key);
      check_eq("kx_keylen", 256'(kx_keylen), 256'(len));
      check_eq("err_clear", 256'(h.rsp_err), 256'(0));
      err_exp = 1'b0;
    end
  endtask

  task automatic send_req(input logic dec, input logic [127:0] d, input bit push, input bit tmo);
    exp_t e;
    int n = 0;
    while (!h.req_ready && n < 600) begin tick(); n++; end
    check_eq("req_ready_wait", 256'(h.req_ready), 256'(1));
    if (push) begin
      e.err  = tmo ? 1'b1 : err_exp;
      e.data = tmo ? 128'h0 : (dec ? dec_model(d) : enc_model(d));
      sb.push_back(e);
    end
    h.req_valid = 1'b1; h.req_dec = dec; h.req_data = d;
    tick();
    h.req_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin tick(); n++; end
    check_eq("drain", 256'(sb.size()), 256'(0));
  endtask

  task automatic blocked_without_key(input string tag);
    int bad = 0;
    h.req_valid = 1'b1; h.req_dec = 1'b0; h.req_data = PT;
    repeat (10) begin
      tick();
      if (h.req_ready || enc_next || dec_start) bad++;
    end
    h.req_valid = 1'b0;
    check_eq(tag, 256'(bad), 256'(0));
    check_eq("nokey_key_ready", 256'(h.key_ready), 256'(1));
  endtask

  initial begin
    logic [127:0] d;
    int bad, n;
    h.key_valid = 1'b0; h.key_in = '0; h.keylen = 1'b0;
    h.req_valid = 1'b0; h.req_dec = 1'b0; h.req_data = '0; h.rsp_ready = 1'b1;

    tick(3);
    check_eq("rst_ctrl", 256'({h.key_ready, h.req_ready, h.rsp_valid, h.rsp_err,
                               kx_init, enc_next, dec_start}), 256'(0));
    check_eq("rst_rsp_data", 256'(h.rsp_data), 256'(0));
    check_eq("rst_kx_key", kx_key, 256'(0));
    rst_n = 1'b1;
    tick();

    blocked_without_key("nokey_req_blocked");

    load_key(KEY0, 1'b0, 1'b1);
    send_req(1'b0, PT, 1'b1, 1'b0);
    drain(100);
    send_req(1'b1, CT, 1'b1, 1'b0);
    drain(100);
    check_eq("dec_window_seen", 256'(dec_samples != 0), 256'(1));

    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_req(1'(i % 2), d, 1'b1, 1'b0);
    end
    drain(200);

    // Backpressure: response must hold while the host stalls.
    h.rsp_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send_req(1'b0, d, 1'b1, 1'b0);
    n = 0;
    while (!h.rsp_valid && n < 100) begin tick(); n++; end
    check_eq("bp_rsp_valid", 256'(h.rsp_valid), 256'(1));
    bad = 0;
    repeat (20) begin
      tick();
      if (!h.rsp_valid || h.rsp_data !== enc_model(d) || h.req_ready) bad++;
    end
    check_eq("bp_stable", 256'(bad), 256'(0));
    h.rsp_ready = 1'b1;
    drain(20);

    // Key reload with a 256-bit key.
    load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             1'b1, 1'b1);
    send_req(1'b1, CT, 1'b1, 1'b0);
    drain(100);

    // Encipher never finishes: zero data with error, error stays sticky afterwards.
    enc_stall = 1'b1;
    send_req(1'b0, PT, 1'b1, 1'b1);
    drain(TIMEOUT + 50);
    enc_stall = 1'b0;
    err_exp = 1'b1;
    send_req(1'b0, PT, 1'b1, 1'b0);
    drain(100);

    // Key expansion never completes.
    kx_tie0 = 1'b1;
    load_key(KEY0, 1'b0, 1'b0);
    tick(TIMEOUT + 1);
    check_eq("kx_tmo_early", 256'({h.rsp_err, h.key_ready}), 256'(0));
    tick();
    check_eq("kx_tmo_err", 256'(h.rsp_err), 256'(1));
    check_eq("kx_tmo_nokey", 256'({h.key_ready, h.req_ready}), 256'(2'b10));
    kx_tie0 = 1'b0;
    load_key(KEY0, 1'b0, 1'b1);
    send_req(1'b0, PT, 1'b1, 1'b0);
    drain(100);

    // Reset in the middle of an encipher.
    enc_stall = 1'b1;
    send_req(1'b0, PT, 1'b0, 1'b0);
    tick(5);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_ctrl", 256'({h.key_ready, h.req_ready, h.rsp_valid, h.rsp_err,
                                  kx_init, enc_next, dec_start}), 256'(0));
    check_eq("midrst_rsp_data", 256'(h.rsp_data), 256'(0));
    check_eq("midrst_enc_plain", 256'(enc_plain), 256'(0));
    check_eq("midrst_kx_key", kx_key, 256'(0));
    rst_n = 1'b1;
    enc_stall = 1'b0;
    err_exp = 1'b0;
    tick(8);
    blocked_without_key("postrst_req_blocked");
    load_key(KEY0, 1'b0, 1'b1);
    send_req(1'b0, PT, 1'b1, 1'b0);
    drain(100);

    check_eq("kx_round_mux", 256'(kx_bad), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
